// File: rtl/counter_event_log.sv
// counter_event_log
//   Sits behind the 4-bit mode counter. It extends the counter's range with a
//   WRAP_W-bit wrap count and records every rollover or load event in a small
//   first-word-fall-through FIFO that a monitor drains over valid/ready.
//
// Ports
//   clk        rising-edge clock shared with the counter
//   reset      asynchronous, active-low; clears all state immediately
//   Q          counter value, sampled with the event
//   rco        counter ripple-carry pulse
//   load       counter load indication
//   mode       counter mode: 00 up, 01 down, 10 down-by-3, 11 load D
//   evt_ready  consumer accepts evt_data this cycle
//   clr_ovf    synchronous clear of ovf and drop_cnt
//   evt_valid  FIFO non-empty
//   evt_data   {type[1:0], wrap[WRAP_W-1:0], q[3:0]}; 0 when empty
//   wrap_cnt   live extended count
//   level      FIFO occupancy, 0..DEPTH
//   ovf        sticky: at least one event was dropped
//   drop_cnt   dropped events, saturating at 15
//
// Handshake: a record transfers on every rising edge where evt_valid and
// evt_ready are both 1. evt_valid never depends on evt_ready, and while
// evt_valid=1 and evt_ready=0 evt_data holds stable.
//
// DEPTH must be a power of two and at least 2.

module counter_event_log #(
  parameter int DEPTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 Q,
  input  logic                       rco,
  input  logic                       load,
  input  logic [1:0]                 mode,
  input  logic                       evt_ready,
  input  logic                       clr_ovf,
  output logic                       evt_valid,
  output logic [2+WRAP_W+4-1:0]      evt_data,
  output logic [WRAP_W-1:0]          wrap_cnt,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic [3:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 + WRAP_W + 4;

  logic [RW-1:0]     mem [DEPTH];
  logic [AW:0]       head;
  logic [AW:0]       tail;
  logic [1:0]        evt_type;
  logic              evt;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [WRAP_W-1:0] wrap_next;

  // Type bits fall straight out of the inputs: 01 rco, 10 load, 11 both.
  assign evt_type  = {load, rco};
  assign evt       = |evt_type;

  // Pointers carry one extra lap bit so full and empty are distinguishable.
  assign evt_valid = (head != tail);
  assign full      = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign level     = tail - head;

  assign pop  = evt_valid & evt_ready;
  // A pop frees the slot the same cycle, so a full FIFO still accepts.
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  assign evt_data = evt_valid ? mem[head[AW-1:0]] : '0;

  // load dominates rco; down and down-by-3 both count a wrap downwards.
  always_comb begin
    wrap_next = wrap_cnt;
    if (load) begin
      wrap_next = '0;
    end else if (rco) begin
      case (mode)
        2'b00:   wrap_next = wrap_cnt + WRAP_W'(1);
        2'b01,
        2'b10:   wrap_next = wrap_cnt - WRAP_W'(1);
        default: wrap_next = wrap_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_cnt <= '0;
      head     <= '0;
      tail     <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // wrap_cnt advances even when the record itself is dropped.
      wrap_cnt <= wrap_next;

      if (push) begin
        mem[tail[AW-1:0]] <= {evt_type, wrap_next, Q};
        tail              <= tail + (AW+1)'(1);
      end
      if (pop) begin
        head <= head + (AW+1)'(1);
      end

      // A drop in the same cycle as a clear wins and restarts the count at 1.
      if (drop) begin
        ovf <= 1'b1;
        if (clr_ovf) begin
          drop_cnt <= 4'd1;
        end else if (drop_cnt != 4'hF) begin
          drop_cnt <= drop_cnt + 4'd1;
        end
      end else if (clr_ovf) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_counter_event_log.sv
// tb_counter_event_log
//   Directed scenarios plus a randomized run of counter_event_log against a
//   queue-based reference model of the event log.

module tb_counter_event_log;

  localparam int DEPTH  = 4;
  localparam int WRAP_W = 8;
  localparam int RW     = 2 + WRAP_W + 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        Q;
  logic              rco;
  logic              load;
  logic [1:0]        mode;
  logic              evt_ready;
  logic              clr_ovf;
  logic              evt_valid;
  logic [RW-1:0]     evt_data;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [2:0]        level;
  logic              ovf;
  logic [3:0]        drop_cnt;

  always #5 clk = ~clk;

  counter_event_log #(.DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Q         (Q),
    .rco       (rco),
    .load      (load),
    .mode      (mode),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .wrap_cnt  (wrap_cnt),
    .level     (level),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [RW-1:0]     exp_q[$];
  logic [WRAP_W-1:0] m_wrap;
  logic              m_ovf;
  int                m_drop;

  function automatic logic [RW-1:0] exp_data();
    return (exp_q.size() > 0) ? exp_q[0] : '0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_wrap = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, advances the model over that edge, and
  // returns 1 ns after the edge with event/clear inputs back at idle.
  task automatic step(input logic r, input logic l, input logic [1:0] m,
                      input logic [3:0] qv, input logic rdy, input logic clr);
    int            sz;
    bit            ev;
    bit            pp;
    bit            dr;
    logic [RW-1:0] rec;
    logic [RW-1:0] dummy;
    rco = r; load = l; mode = m; Q = qv; evt_ready = rdy; clr_ovf = clr;
    sz = exp_q.size();
    ev = r | l;
    pp = (sz > 0) && rdy;
    dr = ev && (sz == DEPTH) && !pp;
    if (l)      m_wrap = '0;
    else if (r) begin
      if (m == 2'd0)      m_wrap = m_wrap + 1;
      else if (m != 2'd3) m_wrap = m_wrap - 1;
    end
    rec = {l, r, m_wrap, qv};
    if (pp) dummy = exp_q.pop_front();
    if (ev && !dr) exp_q.push_back(rec);
    if (dr) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop >= 15) ? 15 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge clk);
    #1;
    rco = 1'b0; load = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 2'd0, 4'd0, 1, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; Q = '0; rco = 0; load = 0; mode = 0; evt_ready = 0; clr_ovf = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", evt_valid); end
    checks++; if (evt_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", evt_data); end
    checks++; if (wrap_cnt !== '0) begin errors++; $display("FAIL reset_wrap got %h exp 0", wrap_cnt); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
    checks++; if (drop_cnt !== 4'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    reset = 1'b1;
  endtask

  task automatic test_rollover();
    step(1, 0, 2'd0, 4'h0, 0, 0);
    checks++; if (wrap_cnt !== 8'h01) begin errors++; $display("FAIL rollover_wrap got %h exp 01", wrap_cnt); end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL rollover_valid got %0b exp 1", evt_valid); end
    checks++; if (evt_data !== {2'b01, 8'h01, 4'h0}) begin errors++; $display("FAIL rollover_data got %h exp %h", evt_data, {2'b01, 8'h01, 4'h0}); end
    step(0, 0, 2'd0, 4'h0, 1, 0);
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rollover_drain_level got %0d exp 0", level); end
  endtask

  task automatic test_load_wins();
    step(1, 0, 2'd0, 4'h0, 1, 0);
    step(1, 0, 2'd0, 4'h0, 1, 0);
    checks++; if (wrap_cnt !== 8'h03) begin errors++; $display("FAIL load_pre_wrap got %h exp 03", wrap_cnt); end
    step(1, 1, 2'd0, 4'h5, 1, 0);
    checks++; if (evt_data !== {2'b11, 8'h00, 4'h5}) begin errors++; $display("FAIL load_data got %h exp %h", evt_data, {2'b11, 8'h00, 4'h5}); end
    checks++; if (wrap_cnt !== 8'h00) begin errors++; $display("FAIL load_wrap got %h exp 00", wrap_cnt); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL load_level got %0d exp 1", level); end
    drain_all();
  endtask

  task automatic test_down_wrap();
    step(1, 0, 2'd1, 4'hF, 0, 0);
    checks++; if (wrap_cnt !== 8'hFF) begin errors++; $display("FAIL down_wrap got %h exp FF", wrap_cnt); end
    checks++; if (evt_data[13:12] !== 2'b01) begin errors++; $display("FAIL down_type got %b exp 01", evt_data[13:12]); end
    checks++; if (evt_data[11:4] !== 8'hFF) begin errors++; $display("FAIL down_rec_wrap got %h exp FF", evt_data[11:4]); end
    drain_all();
  endtask

  task automatic test_overflow();
    logic [RW-1:0] exp_rec;
    for (int i = 0; i < 6; i++) step(1, 0, 2'd0, 4'(i), 0, 0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", ovf); end
    checks++; if (drop_cnt !== 4'd2) begin errors++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
    checks++; if (wrap_cnt !== 8'h05) begin errors++; $display("FAIL ovf_wrap got %h exp 05", wrap_cnt); end
    // Starting from FF, the four kept records carry wraps 00..03.
    for (int i = 0; i < 4; i++) begin
      exp_rec = {2'b01, 8'(i), 4'(i)};
      checks++; if (evt_data !== exp_rec) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, evt_data, exp_rec); end
      step(0, 0, 2'd0, 4'd0, 1, 0);
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b exp 0", evt_valid); end
    step(0, 0, 2'd0, 4'd0, 0, 1);
    checks++; if (ovf !== 1'b0 || drop_cnt !== 4'd0) begin errors++; $display("FAIL ovf_clear got %0b/%0d exp 0/0", ovf, drop_cnt); end
    // Saturation: 4 kept, 20 dropped.
    for (int i = 0; i < 24; i++) step(1, 0, 2'd0, 4'd0, 0, 0);
    checks++; if (drop_cnt !== 4'd15) begin errors++; $display("FAIL ovf_saturate got %0d exp 15", drop_cnt); end
    // Drop and clear in the same cycle: the drop wins.
    step(1, 0, 2'd0, 4'd0, 0, 1);
    checks++; if (ovf !== 1'b1 || drop_cnt !== 4'd1) begin errors++; $display("FAIL ovf_clr_vs_drop got %0b/%0d exp 1/1", ovf, drop_cnt); end
    step(0, 0, 2'd0, 4'd0, 0, 1);
    checks++; if (ovf !== 1'b0 || drop_cnt !== 4'd0) begin errors++; $display("FAIL ovf_clear2 got %0b/%0d exp 0/0", ovf, drop_cnt); end
    drain_all();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) step(1, 0, 2'd0, 4'(i), 0, 0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_full got %0d exp 4", level); end
    step(1, 0, 2'd0, 4'hA, 1, 0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_level got %0d exp 4", level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %0b exp 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_data !== exp_data()) begin errors++; $display("FAIL fpp_drain%0d got %h exp %h", i, evt_data, exp_data()); end
      if (i == 3) begin
        checks++; if (evt_data[3:0] !== 4'hA) begin errors++; $display("FAIL fpp_last_q got %h exp A", evt_data[3:0]); end
      end
      step(0, 0, 2'd0, 4'd0, 1, 0);
    end
  endtask

  task automatic test_empty_ready();
    step(0, 0, 2'd0, 4'd0, 1, 0);
    step(0, 0, 2'd0, 4'd0, 1, 0);
    checks++; if (level !== 3'd0 || evt_valid !== 1'b0) begin errors++; $display("FAIL empty_ready got %0d/%0b exp 0/0", level, evt_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] qv;
    for (int i = 0; i < 10; i++) begin
      qv = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1, 2'd0, qv, 1, 0);
      checks++; if (evt_data !== exp_data() || level !== 3'd1) begin errors++; $display("FAIL b2b%0d got %h/%0d exp %h/1", i, evt_data, level, exp_data()); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %0b exp 0", ovf); end
    drain_all();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      checks++; if (evt_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d got %0b", i, evt_valid); end
      checks++; if (evt_data !== exp_data()) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", i, evt_data, exp_data()); end
      checks++; if (level !== 3'(exp_q.size())) begin errors++; $display("FAIL rnd_level c%0d got %0d exp %0d", i, level, exp_q.size()); end
      checks++; if (wrap_cnt !== m_wrap) begin errors++; $display("FAIL rnd_wrap c%0d got %h exp %h", i, wrap_cnt, m_wrap); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d got %0b exp %0b", i, ovf, m_ovf); end
      checks++; if (drop_cnt !== 4'(m_drop)) begin errors++; $display("FAIL rnd_drop c%0d got %0d exp %0d", i, drop_cnt, m_drop); end
    end
  endtask

  task automatic test_async_reset();
    drain_all();
    step(0, 0, 2'd0, 4'd0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 2'd0, 4'(i), 0, 0);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL arst_pre_level got %0d exp 3", level); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b exp 0", evt_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d exp 0", level); end
    checks++; if (wrap_cnt !== '0) begin errors++; $display("FAIL arst_wrap got %h exp 0", wrap_cnt); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 0, 2'd0, 4'h7, 0, 0);
    checks++; if (evt_data !== {2'b01, 8'h01, 4'h7}) begin errors++; $display("FAIL arst_first got %h exp %h", evt_data, {2'b01, 8'h01, 4'h7}); end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_load_wins();
    test_down_wrap();
    test_overflow();
    test_full_push_pop();
    test_empty_ready();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_event_log.md
# counter_event_log

Downstream consumer of the 4-bit mode counter (`Q`, `rco`, `load`). It extends the counter's range with an 8-bit wrap count and logs every rollover or load event into a small FIFO. The FIFO drains over a valid/ready interface to a monitor or a scoreboard-side checker. It runs on the counter's clock and takes the counter's outputs directly, with no retiming.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of two, at least 2.
- `WRAP_W`, 8: width of the extended wrap counter.
- `clk`  in  1  rising-edge clock shared with the counter.
- `reset`  in  1  asynchronous, active-low reset. Asserting it clears all state immediately.
- `Q`  in  4  counter value.
- `rco`  in  1  counter ripple-carry pulse.
- `load`  in  1  counter load indication.
- `mode`  in  2  counter mode: 00 up, 01 down, 10 down-by-3, 11 load D.
- `evt_ready`  in  1  consumer accepts `evt_data` this cycle.
- `clr_ovf`  in  1  synchronous clear of `ovf` and `drop_cnt`.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_data`  out  2+WRAP_W+4  event record {type[1:0], wrap[WRAP_W-1:0], q[3:0]}.
- `wrap_cnt`  out  WRAP_W  live extended count, upper part.
- `level`  out  log2(DEPTH)+1  FIFO occupancy.
- `ovf`  out  1  sticky flag: an event was dropped.
- `drop_cnt`  out  4  dropped events, saturating at 15.

## Operation
- **Event detection**
  - Sampled at each rising `clk`.
  - An event occurs when `rco|load` is 1.
  - Type encoding: 01 = rco only, 10 = load only, 11 = both.
- **`wrap_cnt` update**, in priority order:
  - `load`: clear to 0.
  - Else `rco` with `mode`=00: increment, mod 2^WRAP_W.
  - Else `rco` with `mode`=01 or 10: decrement, mod 2^WRAP_W.
  - Else `rco` with `mode`=11: hold.
- **Event record contents**
  - `wrap` holds the post-update `wrap_cnt`.
  - `q` holds `Q` sampled in the same cycle.
- **FIFO**
  - Registered memory with head/tail pointers of log2(DEPTH)+1 bits.
  - First-word fall-through: `evt_data` = mem[head] whenever `evt_valid`=1, and 0 when empty.
- **Pop and push**
  - Pop occurs when `evt_valid & evt_ready`.
  - Push occurs when an event is present and either (`level`<DEPTH) or a pop happens in the same cycle.
  - Push and pop in the same cycle leave `level` unchanged, including when full.
- **Overflow**
  - Condition: event present, FIFO full, and no pop that cycle.
  - Response: the event is dropped, `ovf` is set to 1, and `drop_cnt` is incremented, saturating at 15.
  - `wrap_cnt` still updates on a dropped event.
- **Overflow clear**
  - `clr_ovf`=1 clears `ovf` and `drop_cnt` at the next edge.
  - If a drop occurs in the same cycle as the clear, the drop wins: `ovf`=1 and `drop_cnt`=1.
- **Output stability:** while `evt_valid`=1 and `evt_ready`=0, `evt_data` holds stable.

## Timing
- **Reset values:** `evt_valid`=0, `evt_data`=0, `wrap_cnt`=0, `level`=0, `ovf`=0, `drop_cnt`=0, pointers=0.
- **Reset mid-operation:** asserting `reset` discards all FIFO contents asynchronously. The first event is sampled at the first rising edge after `reset` deasserts.
- **`wrap_cnt` latency:** `wrap_cnt` reflects an event one cycle after the edge that sampled it.
- **Push-to-valid latency:** an event pushed into an empty FIFO raises `evt_valid` one cycle later, with that record on `evt_data`.
- **Empty FIFO with `evt_ready`=1:** nothing is popped, and `level` stays 0.
- **Back-to-back events:** every cycle can hold an event (e.g. mode 00 with `load` held high). Sustained throughput is 1 event/cycle when `evt_ready`=1.
- **Pointer wrap:** the index wraps modulo DEPTH. Full is detected when the index bits are equal and the MSB differs.

## Test plan
- **Reset and rollover:** reset low for 3 cycles, release, `mode`=00, one `rco` pulse with Q=0.
  - Next cycle: `wrap_cnt`=1, `evt_valid`=1, `evt_data`={01,8'h01,4'h0}.
- **Load clears, load wins:** after 3 up-rollovers (`wrap_cnt`=3), assert `rco`=1 and `load`=1 together with Q=5.
  - Record {11,8'h00,4'h5}, and `wrap_cnt`=0.
- **Down-wrap:** from `wrap_cnt`=0, `mode`=01, one `rco` pulse.
  - `wrap_cnt`=8'hFF, record type 01, wrap=8'hFF.
- **Overflow and clear:** `evt_ready`=0, 6 consecutive events.
  - `level`=4, `ovf`=1, `drop_cnt`=2.
  - The 4 oldest records drain in order.
  - `clr_ovf` pulse gives `ovf`=0, `drop_cnt`=0.
- **Full push+pop:** FIFO full, `evt_ready`=1, event present in the same cycle.
  - `level` stays 4, `ovf` stays 0, and the new record appears last in drain order.
- **Async reset mid-drain:** with `level`=3, pull `reset` low between edges.
  - `evt_valid`=0, `level`=0, `wrap_cnt`=0 immediately, before the next edge.
